// File: rtl/mvm_stream.sv
// mvm_stream: multi-lane signed matrix-vector engine with requantisation
// and a credit-protected output FIFO with valid/ready backpressure.
module mvm_stream #(
  parameter int IWIDTH        = 8,
  parameter int DOT_LEN       = 8,
  parameter int MEM_DATAW     = IWIDTH * DOT_LEN,
  parameter int ACCW          = 32,
  parameter int OWIDTH        = 16,
  parameter int VEC_MEM_DEPTH = 256,
  parameter int VEC_ADDRW     = $clog2(VEC_MEM_DEPTH),
  parameter int MAT_MEM_DEPTH = 512,
  parameter int MAT_ADDRW     = $clog2(MAT_MEM_DEPTH),
  parameter int NUM_OLANES    = 8,
  parameter int OFIFO_DEPTH   = 4,
  parameter int SHW           = $clog2(ACCW)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MEM_DATAW-1:0]         i_vec_wdata,
  input  logic [VEC_ADDRW-1:0]         i_vec_waddr,
  input  logic                         i_vec_wen,
  input  logic [MEM_DATAW-1:0]         i_mat_wdata,
  input  logic [MAT_ADDRW-1:0]         i_mat_waddr,
  input  logic [NUM_OLANES-1:0]        i_mat_wen,
  input  logic                         i_start,
  input  logic [VEC_ADDRW-1:0]         i_vec_start_addr,
  input  logic [VEC_ADDRW:0]           i_vec_num_words,
  input  logic [MAT_ADDRW-1:0]         i_mat_start_addr,
  input  logic [MAT_ADDRW:0]           i_num_out_rows,
  input  logic [SHW-1:0]               i_shift,
  input  logic                         i_relu_en,
  output logic                         o_busy,
  output logic [NUM_OLANES*OWIDTH-1:0] o_result,
  output logic                         o_valid,
  input  logic                         i_ready
);

  localparam int LOG   = $clog2(DOT_LEN);
  localparam int NODES = 2 * DOT_LEN - 1;
  localparam int TAGS  = 2 + LOG;
  localparam int TOP   = TAGS - 1;
  localparam int CNTW  = $clog2(OFIFO_DEPTH + 1) + 1;
  localparam int PTRW  = $clog2(OFIFO_DEPTH);

  localparam logic signed [ACCW-1:0] SMAX =
    {{(ACCW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN =
    {{(ACCW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_n;

  logic [VEC_ADDRW-1:0] r_vstart;
  logic [VEC_ADDRW:0]   r_nw;
  logic [MAT_ADDRW:0]   r_nr;
  logic [SHW-1:0]       r_shift;
  logic                 r_relu;

  logic [VEC_ADDRW:0]   r_w;
  logic [MAT_ADDRW:0]   r_r;
  logic [VEC_ADDRW-1:0] r_vaddr;
  logic [MAT_ADDRW-1:0] r_maddr;

  logic [CNTW-1:0] r_infl;
  logic [CNTW-1:0] r_fcnt;
  logic [PTRW-1:0] r_wp, r_rp;

  logic w_start, w_issue, w_first, w_last_word, w_last_row;
  logic w_credit, w_push, w_pop;

  logic [MEM_DATAW-1:0] r_vmem [VEC_MEM_DEPTH];
  logic [MEM_DATAW-1:0] r_mmem [NUM_OLANES][MAT_MEM_DEPTH];
  logic [MEM_DATAW-1:0] r_vdata;
  logic [MEM_DATAW-1:0] r_mdata [NUM_OLANES];

  logic signed [ACCW-1:0] r_node [NUM_OLANES][NODES];
  logic signed [ACCW-1:0] r_acc  [NUM_OLANES];
  logic signed [ACCW-1:0] w_sh   [NUM_OLANES];
  logic                   r_acc_v;
  logic [TAGS-1:0]        r_tv, r_tf, r_tl;

  logic [NUM_OLANES*OWIDTH-1:0] w_q;
  logic [NUM_OLANES*OWIDTH-1:0] r_fmem [OFIFO_DEPTH];

  function automatic logic signed [ACCW-1:0] f_mul(
    input logic [IWIDTH-1:0] a,
    input logic [IWIDTH-1:0] b
  );
    logic signed [2*IWIDTH-1:0] p;
    p = $signed({{IWIDTH{a[IWIDTH-1]}}, a})
      * $signed({{IWIDTH{b[IWIDTH-1]}}, b});
    return {{(ACCW-2*IWIDTH){p[2*IWIDTH-1]}}, p};
  endfunction

  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_first     = (r_w == '0);
  assign w_last_word = (r_w == r_nw - 1'b1);
  assign w_last_row  = (r_r == r_nr - 1'b1);
  assign w_credit    = (r_infl + r_fcnt) < CNTW'(OFIFO_DEPTH);
  assign w_push      = r_acc_v;
  assign o_valid     = (r_fcnt != '0);
  assign w_pop       = o_valid && i_ready;
  assign o_busy      = (r_state != S_IDLE);
  assign o_result    = o_valid ? r_fmem[r_rp] : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // FSM next state and issue decision (row start needs a FIFO credit)
  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_vec_num_words == '0 || i_num_out_rows == '0)
            w_state_n = S_DRAIN;
          else
            w_state_n = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = !w_first || w_credit;
        if (w_issue && w_last_word && w_last_row)
          w_state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_infl == '0 && r_fcnt == '0)
          w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // config latch and incremental address generation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vstart <= '0;
      r_nw     <= '0;
      r_nr     <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      r_w      <= '0;
      r_r      <= '0;
      r_vaddr  <= '0;
      r_maddr  <= '0;
    end else if (w_start) begin
      r_vstart <= i_vec_start_addr;
      r_nw     <= i_vec_num_words;
      r_nr     <= i_num_out_rows;
      r_shift  <= i_shift;
      r_relu   <= i_relu_en;
      r_w      <= '0;
      r_r      <= '0;
      r_vaddr  <= i_vec_start_addr;
      r_maddr  <= i_mat_start_addr;
    end else if (w_issue) begin
      if (w_last_word) begin
        r_w     <= '0;
        r_r     <= r_r + 1'b1;
        r_vaddr <= r_vstart;
      end else begin
        r_w     <= r_w + 1'b1;
        r_vaddr <= (r_vaddr == VEC_ADDRW'(VEC_MEM_DEPTH-1))
                 ? '0 : r_vaddr + 1'b1;
      end
      r_maddr <= (r_maddr == MAT_ADDRW'(MAT_MEM_DEPTH-1))
               ? '0 : r_maddr + 1'b1;
    end
  end

  // vector memory: write any time, registered read on issue
  always_ff @(posedge clk) begin
    if (i_vec_wen) r_vmem[i_vec_waddr] <= i_vec_wdata;
    if (w_issue)   r_vdata <= r_vmem[r_vaddr];
  end

  // per-lane matrix memories sharing one read address
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OLANES; j++) begin
      if (i_mat_wen[j]) r_mmem[j][i_mat_waddr] <= i_mat_wdata;
      if (w_issue)      r_mdata[j] <= r_mmem[j][r_maddr];
    end
  end

  // products at the leaves, one pipelined adder level per heap row
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OLANES; j++) begin
      for (int k = 0; k < DOT_LEN; k++)
        r_node[j][DOT_LEN-1+k] <= f_mul(
          r_vdata[k*IWIDTH +: IWIDTH],
          r_mdata[j][k*IWIDTH +: IWIDTH]);
      for (int n = 0; n < DOT_LEN - 1; n++)
        r_node[j][n] <= r_node[j][2*n+1] + r_node[j][2*n+2];
    end
  end

  // valid/first/last tags travel alongside memory read and tree
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv    <= '0;
      r_tf    <= '0;
      r_tl    <= '0;
      r_acc_v <= 1'b0;
    end else begin
      r_tv    <= {r_tv[TAGS-2:0], w_issue};
      r_tf    <= {r_tf[TAGS-2:0], w_first};
      r_tl    <= {r_tl[TAGS-2:0], w_last_word};
      r_acc_v <= r_tv[TOP] && r_tl[TOP];
    end
  end

  // accumulator: first word of a row loads, later words add (wrapping)
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OLANES; j++)
      if (r_tv[TOP])
        r_acc[j] <= r_tf[TOP] ? r_node[j][0]
                              : r_acc[j] + r_node[j][0];
  end

  // requantise: floor shift, optional relu, saturate to OWIDTH
  always_comb begin
    w_q = '0;
    for (int j = 0; j < NUM_OLANES; j++) begin
      w_sh[j] = r_acc[j] >>> r_shift;
      if (r_relu && w_sh[j][ACCW-1]) w_sh[j] = '0;
      if (w_sh[j] > SMAX)
        w_q[j*OWIDTH +: OWIDTH] = SMAX[OWIDTH-1:0];
      else if (w_sh[j] < SMIN)
        w_q[j*OWIDTH +: OWIDTH] = SMIN[OWIDTH-1:0];
      else
        w_q[j*OWIDTH +: OWIDTH] = w_sh[j][OWIDTH-1:0];
    end
  end

  // FIFO storage doubles as the requantisation register
  always_ff @(posedge clk) begin
    if (w_push) r_fmem[r_wp] <= w_q;
  end

  // FIFO pointers/count and rows-in-flight credit tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_infl <= '0;
    end else begin
      if (w_push)
        r_wp <= (r_wp == PTRW'(OFIFO_DEPTH-1)) ? '0 : r_wp + 1'b1;
      if (w_pop)
        r_rp <= (r_rp == PTRW'(OFIFO_DEPTH-1)) ? '0 : r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      unique case ({w_issue && w_first, w_push})
        2'b10:   r_infl <= r_infl + 1'b1;
        2'b01:   r_infl <= r_infl - 1'b1;
        default: r_infl <= r_infl;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream.sv
// tb_mvm_stream: directed test of mvm_stream with hand-computed
// expected dot products, requantisation, backpressure and control edges.
module tb_mvm_stream;

  localparam int IW  = 8;
  localparam int DL  = 8;
  localparam int MDW = IW * DL;
  localparam int OW  = 16;
  localparam int VAW = 8;
  localparam int MAW = 9;
  localparam int NL  = 8;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [MDW-1:0] i_vec_wdata = '0;
  logic [VAW-1:0] i_vec_waddr = '0;
  logic           i_vec_wen = 1'b0;
  logic [MDW-1:0] i_mat_wdata = '0;
  logic [MAW-1:0] i_mat_waddr = '0;
  logic [NL-1:0]  i_mat_wen = '0;
  logic           i_start = 1'b0;
  logic [VAW-1:0] i_vec_start_addr = '0;
  logic [VAW:0]   i_vec_num_words = '0;
  logic [MAW-1:0] i_mat_start_addr = '0;
  logic [MAW:0]   i_num_out_rows = '0;
  logic [SHW-1:0] i_shift = '0;
  logic           i_relu_en = 1'b0;
  logic           o_busy;
  logic [NL*OW-1:0] o_result;
  logic           o_valid;
  logic           i_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  mvm_stream dut (
    .clk              (clk),
    .rst              (rst),
    .i_vec_wdata      (i_vec_wdata),
    .i_vec_waddr      (i_vec_waddr),
    .i_vec_wen        (i_vec_wen),
    .i_mat_wdata      (i_mat_wdata),
    .i_mat_waddr      (i_mat_waddr),
    .i_mat_wen        (i_mat_wen),
    .i_start          (i_start),
    .i_vec_start_addr (i_vec_start_addr),
    .i_vec_num_words  (i_vec_num_words),
    .i_mat_start_addr (i_mat_start_addr),
    .i_num_out_rows   (i_num_out_rows),
    .i_shift          (i_shift),
    .i_relu_en        (i_relu_en),
    .o_busy           (o_busy),
    .o_result         (o_result),
    .o_valid          (o_valid),
    .i_ready          (i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] lane(input int j);
    logic signed [OW-1:0] t;
    t = o_result[j*OW +: OW];
    return 64'(t);
  endfunction

  function automatic logic [MDW-1:0] rep(input int v);
    logic [MDW-1:0] d;
    for (int k = 0; k < DL; k++) d[k*IW +: IW] = IW'(v);
    return d;
  endfunction

  task automatic wvec(input int a, input logic [MDW-1:0] d);
    i_vec_waddr = VAW'(a);
    i_vec_wdata = d;
    i_vec_wen   = 1'b1;
    tick();
    i_vec_wen   = 1'b0;
  endtask

  task automatic wmat(input int l, input int a,
                      input logic [MDW-1:0] d);
    i_mat_waddr = MAW'(a);
    i_mat_wdata = d;
    i_mat_wen   = NL'(1) << l;
    tick();
    i_mat_wen   = '0;
  endtask

  task automatic start(input int vs, input int w, input int ms,
                       input int r, input int sh, input int relu);
    i_vec_start_addr = VAW'(vs);
    i_vec_num_words  = (VAW+1)'(w);
    i_mat_start_addr = MAW'(ms);
    i_num_out_rows   = (MAW+1)'(r);
    i_shift          = SHW'(sh);
    i_relu_en        = relu[0];
    i_start          = 1'b1;
    tick();
    i_start          = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      if (o_valid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200; c++) begin
      if (!o_busy) break;
      tick();
    end
    chk(tag, o_busy, 0);
  endtask

  task automatic one(input string tag, input int l,
                     input logic signed [63:0] exp);
    int lat;
    wait_valid(lat);
    chk({tag, "_arrive"}, lat >= 0, 1);
    chk(tag, lane(l), exp);
    tick();
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int lat, n, vc, bc;
    logic [4:0] pat;
    logic [MDW-1:0] d;

    tick(); tick(); tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result === '0, 1);
    rst = 1'b0;
    tick();

    // basic: 1+2+..+8 = 36, exact latency and single-cycle valid
    wvec(0, rep(1));
    for (int k = 0; k < DL; k++) d[k*IW +: IW] = IW'(k + 1);
    wmat(0, 0, d);
    start(0, 1, 0, 1, 0, 0);
    chk("basic_busy", o_busy, 1);
    wait_valid(lat);
    chk("basic_lat", lat, 7);
    chk("basic_res", lane(0), 36);
    tick();
    chk("basic_pulse", o_valid, 0);
    chk("basic_busy_tail", o_busy, 1);
    tick();
    chk("basic_busy_fall", o_busy, 0);

    // multi-word signed: 4 * 8 * (-2*3) = -192
    for (int a = 10; a < 14; a++) wvec(a, rep(-2));
    for (int a = 20; a < 24; a++) wmat(3, a, rep(3));
    start(10, 4, 20, 1, 0, 0);
    wait_valid(lat);
    chk("multi_lat", lat, 10);
    chk("multi_res", lane(3), -192);
    tick();
    wait_idle("multi_idle");
    start(10, 4, 20, 1, 0, 1);
    one("relu", 3, 0);
    start(10, 4, 20, 1, 7, 0);
    one("floor_shift", 3, -2);

    // saturation and shift: raw 516128 / -520192
    for (int a = 30; a < 34; a++) wvec(a, rep(127));
    for (int a = 34; a < 38; a++) wvec(a, rep(-128));
    for (int a = 40; a < 44; a++) wmat(1, a, rep(127));
    start(30, 4, 40, 1, 0, 0);
    one("sat_pos", 1, 32767);
    start(30, 4, 40, 1, 4, 0);
    one("shift4", 1, 32258);
    start(34, 4, 40, 1, 0, 0);
    one("sat_neg", 1, -32768);

    // backpressure: 10 rows, lane2 row r gives 8*(r+1)
    wvec(50, rep(1));
    for (int r = 0; r < 10; r++) wmat(2, 100 + r, rep(r + 1));
    i_ready = 1'b0;
    start(50, 1, 100, 10, 0, 0);
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 10) begin
        chk("bp_valid10", o_valid, 1);
        chk("bp_head10", lane(2), 8);
      end
    end
    chk("bp_valid40", o_valid, 1);
    chk("bp_head40", lane(2), 8);
    chk("bp_busy", o_busy, 1);
    i_ready = 1'b1;
    n = 0;
    pat = '0;
    for (int c = 0; c < 300; c++) begin
      if (c < 5) pat[c] = o_valid;
      if (o_valid) begin
        chk($sformatf("bp_row%0d", n), lane(2), 8 * (n + 1));
        n++;
        if (n == 10) break;
      end
      tick();
    end
    chk("bp_count", n, 10);
    chk("bp_four_buffered", pat, 5'b01111);
    tick();
    chk("bp_busy_tail", o_busy, 1);
    chk("bp_no_extra", o_valid, 0);
    tick();
    chk("bp_busy_fall", o_busy, 0);

    // start while busy ignored: config stays at shift 0
    start(0, 1, 0, 1, 0, 0);
    i_vec_start_addr = VAW'(10);
    i_vec_num_words  = (VAW+1)'(4);
    i_shift          = SHW'(3);
    i_relu_en        = 1'b1;
    i_start          = 1'b1;
    tick();
    i_start          = 1'b0;
    vc = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_valid) begin
        vc++;
        chk("ign_res", lane(0), 36);
      end
      tick();
    end
    chk("ign_count", vc, 1);
    chk("ign_idle", o_busy, 0);

    // R=0 and W=0: busy exactly one cycle, no output
    start(0, 1, 0, 0, 0, 0);
    vc = 0; bc = 0;
    for (int c = 0; c < 10; c++) begin
      vc += int'(o_valid);
      bc += int'(o_busy);
      tick();
    end
    chk("r0_busy", bc, 1);
    chk("r0_valid", vc, 0);
    start(0, 0, 0, 3, 0, 0);
    vc = 0; bc = 0;
    for (int c = 0; c < 10; c++) begin
      vc += int'(o_valid);
      bc += int'(o_busy);
      tick();
    end
    chk("w0_busy", bc, 1);
    chk("w0_valid", vc, 0);

    // vector address wrap: words 255 then 0 -> 8*1*1 + 8*2*3
    wvec(255, rep(1));
    wvec(0, rep(2));
    wmat(4, 200, rep(1));
    wmat(4, 201, rep(3));
    start(255, 2, 200, 1, 0, 0);
    one("wrap", 4, 56);

    // reset with two results buffered, then rerun from kept memory
    i_ready = 1'b0;
    start(50, 1, 100, 10, 0, 0);
    for (int t = 0; t < 8; t++) tick();
    chk("mid_pre_valid", o_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_valid", o_valid, 0);
    chk("mid_busy", o_busy, 0);
    rst = 1'b0;
    i_ready = 1'b1;
    tick();
    chk("mid_quiet", o_valid, 0);
    start(50, 1, 100, 2, 0, 0);
    wait_valid(lat);
    chk("rerun_lat", lat, 7);
    chk("rerun_row0", lane(2), 8);
    tick();
    chk("rerun_v1", o_valid, 1);
    chk("rerun_row1", lane(2), 16);
    tick();
    chk("rerun_end", o_valid, 0);
    wait_idle("rerun_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_stream.md
Name: mvm_stream

Overview:
- Parametrised next-generation matrix-vector multiply engine: NUM_OLANES output lanes, each computing signed dot products of DOT_LEN-element words from a shared vector memory and a per-lane matrix memory.
- Adds signed arithmetic, a configurable accumulator width, and a requantisation stage (arithmetic right shift, optional ReLU, saturation to OWIDTH).
- Adds an output FIFO with valid/ready backpressure and credit-based issue stalling.
- Sits between the host write/config interface and a downstream consumer that may stall.

Parameters:
- IWIDTH, 8, signed element width.
- DOT_LEN, 8, elements per memory word (power of 2, ≥2).
- MEM_DATAW, IWIDTH*DOT_LEN, memory word width.
- ACCW, 32, accumulator width (≥ 2*IWIDTH + clog2(DOT_LEN)).
- OWIDTH, 16, signed result width after requantisation (≤ ACCW).
- VEC_MEM_DEPTH, 256, vector memory words; VEC_ADDRW = clog2 of it.
- MAT_MEM_DEPTH, 512, words per lane matrix memory; MAT_ADDRW = clog2 of it.
- NUM_OLANES, 8, output lanes.
- OFIFO_DEPTH, 4, output FIFO entries (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_vec_wdata  in  MEM_DATAW  vector write data; element k at bits [k*IWIDTH +: IWIDTH].
- i_vec_waddr  in  VEC_ADDRW  vector write address.
- i_vec_wen  in  1  vector write enable.
- i_mat_wdata  in  MEM_DATAW  matrix write data.
- i_mat_waddr  in  MAT_ADDRW  matrix write address.
- i_mat_wen  in  NUM_OLANES  per-lane matrix write enable.
- i_start  in  1  start pulse.
- i_vec_start_addr  in  VEC_ADDRW  first vector word.
- i_vec_num_words  in  VEC_ADDRW+1  words per dot product (W).
- i_mat_start_addr  in  MAT_ADDRW  first matrix word.
- i_num_out_rows  in  MAT_ADDRW+1  results per lane (R).
- i_shift  in  clog2(ACCW)  right-shift amount.
- i_relu_en  in  1  clamp negatives to 0.
- o_busy  out  1  operation in progress.
- o_result  out  NUM_OLANES*OWIDTH  lane j at [j*OWIDTH +: OWIDTH].
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  consumer accepts head when o_valid&i_ready.

Behaviour:
- Reset: FSM to IDLE; o_busy=0, o_valid=0, o_result=0; FIFO flushed; all in-flight pipeline valids cleared. Memory contents are not cleared. Reset mid-operation discards all pending results.
- Memories: 1-cycle registered read. Same-address read and write in one cycle returns old data. Writes are permitted at any time; results are undefined if a location under read is overwritten during an operation.
- i_start is accepted only in IDLE. Config inputs are latched on the accept cycle. i_start while busy is ignored.
- FSM states:
  - IDLE.
  - RUN: issue reads.
  - DRAIN: wait until the pipeline is empty and the FIFO is empty, then go to IDLE.
  - Transitions: IDLE→RUN on accepted start; RUN→DRAIN after the last word of the last row is issued.
  - If W=0 or R=0: IDLE→DRAIN with no outputs; o_busy is high exactly 1 cycle.
- o_busy: 1 from the cycle after start accept until the cycle after the last result is popped.
- Issue order: row r (0..R-1), word w (0..W-1). vec addr = vec_start+w; mat addr = mat_start+r*W+w, computed incrementally with no multiplier. Both addresses wrap modulo memory depth.
- Credit: the first word of a row issues only if rows_in_flight + fifo_count < OFIFO_DEPTH. Words within a row issue back-to-back with no gaps. The FIFO can never overflow.
- Arithmetic:
  - Products are signed IWIDTH×IWIDTH.
  - Adder tree is pipelined: DOT_LAT = 1 + clog2(DOT_LEN) cycles.
  - Sum is sign-extended to ACCW; accumulation wraps modulo 2^ACCW.
  - The first word of a row loads the accumulator; the remaining words add to it.
- Requantisation (1 register stage), applied in this order:
  - Arithmetic right shift by i_shift (floor).
  - If i_relu_en, negative values become 0.
  - Saturate to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
- Latency: with the FIFO empty and i_ready=1, o_valid for a row rises DOT_LAT+3 cycles after that row's last-word read is issued (7 for defaults).
- FIFO:
  - First-word-fall-through; o_result is valid whenever o_valid=1.
  - Head is held stable while o_valid&!i_ready.
  - Simultaneous push and pop is allowed, including when full after a pop.
  - o_result is don't-care when o_valid=0.
- All lanes advance in lockstep; a single o_valid covers all lanes.

Test Plan:
- Basic: DOT_LEN=8, vec word0 all 1, lane0 word0 = 1..8, W=1, R=1, shift 0, i_ready=1 → lane0 result 36, o_valid exactly 1 cycle, 7 cycles after the issue cycle.
- Multi-word and signed: W=4, vec all -2, lane3 all 3 → lane3 -192. With i_relu_en=1 → 0.
- Saturation and shift: vec all 127, mat all 127, W=4 → 516128. Shift 0 → 32767. Shift 4 → 32258. Vec all -128, mat 127, shift 0 → -32768.
- Backpressure: R=10, i_ready=0 for 40 cycles → exactly 4 entries buffered, o_valid held, head stable, issue stalls. Then i_ready=1 → 10 rows arrive in order, none lost or duplicated; o_busy falls after the 10th pop.
- Control edges: i_start while busy ignored (config unchanged). R=0 → o_busy high 1 cycle, no o_valid. Address wrap: vec_start=255, W=2 reads words 255, 0.
- Reset mid-run: assert rst during RUN with 2 results buffered → next cycle o_valid=0, o_busy=0. A new start then produces correct results using the preserved memory contents.
